// File: rtl/hms_clock_ctrl.sv
// HH:MM:SS timekeeper with a two-button set mode and a per-digit blink mask.
// Buttons are synchronised and debounced; one event is emitted per accepted press.
module hms_clock_ctrl #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned DEB_CYC   = 500000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_btn_mode,
    input  logic       i_btn_up,
    output logic [5:0] o_hour,
    output logic [5:0] o_min,
    output logic [5:0] o_sec,
    output logic [1:0] o_mode,
    output logic [5:0] o_blank,
    output logic       o_tick
);

    localparam int unsigned TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [TW-1:0] TickMax  = TW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DebMax   = DW'(DEB_CYC - 1);
    localparam logic [BW-1:0] BlinkMax = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StSetHour = 2'd1,
        StSetMin  = 2'd2,
        StSetSec  = 2'd3
    } mode_e;

    // Index 0 is the mode button, index 1 is the up button.
    logic [1:0]    sync1_q, sync2_q, acc_q, ev_q;
    logic [DW-1:0] deb_cnt_q [2];

    mode_e         mode_q, mode_d;
    logic [5:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_q, tick_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [5:0]    blank_q, blank_d;

    logic          mode_ev, up_ev, clr_blink;

    assign mode_ev = ev_q[0];
    // A simultaneous mode event swallows the up event.
    assign up_ev   = ev_q[1] & ~ev_q[0];

    // Synchronise raw buttons, debounce them and emit a pulse on each accepted press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            acc_q        <= '0;
            ev_q         <= '0;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
        end else begin
            sync1_q <= {i_btn_up, i_btn_mode};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                ev_q[i] <= 1'b0;
                if (sync2_q[i] == acc_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DebMax) begin
                    acc_q[i]     <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                    ev_q[i]      <= sync2_q[i];
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Next-state for mode, time, tick divider and blink mask.
    always_comb begin
        mode_d      = mode_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        clr_blink   = 1'b0;
        tick_cnt_d  = '0;
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        blank_d     = 6'b000000;

        if (mode_ev) begin
            clr_blink = 1'b1;
            case (mode_q)
                StRun:     mode_d = StSetHour;
                StSetHour: mode_d = StSetMin;
                StSetMin:  mode_d = StSetSec;
                default:   mode_d = StRun;
            endcase
        end else if (up_ev && (mode_q != StRun)) begin
            clr_blink = 1'b1;
            case (mode_q)
                StSetHour: hour_d = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
                StSetMin:  min_d  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                default:   sec_d  = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
            endcase
        end else if ((mode_q == StRun) && tick_q) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d  = 6'd0;
                    hour_d = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        // Divider only advances while staying in RUN; entering RUN restarts it at 0.
        if ((mode_q == StRun) && (mode_d == StRun)) begin
            tick_cnt_d = (tick_cnt_q == TickMax) ? '0 : tick_cnt_q + TW'(1);
        end
        tick_d = (mode_d == StRun) && (tick_cnt_d == TickMax);

        if (!clr_blink && (mode_d != StRun)) begin
            if (blink_cnt_q == BlinkMax) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                phase_d     = phase_q;
            end
        end

        if (phase_d) begin
            case (mode_d)
                StSetHour: blank_d = 6'b110000;
                StSetMin:  blank_d = 6'b001100;
                StSetSec:  blank_d = 6'b000011;
                default:   blank_d = 6'b000000;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= StRun;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            tick_cnt_q  <= '0;
            tick_q      <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            blank_q     <= '0;
        end else begin
            mode_q      <= mode_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            tick_cnt_q  <= tick_cnt_d;
            tick_q      <= tick_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            blank_q     <= blank_d;
        end
    end

    assign o_hour  = hour_q;
    assign o_min   = min_q;
    assign o_sec   = sec_q;
    assign o_mode  = mode_q;
    assign o_blank = blank_q;
    assign o_tick  = tick_q;

endmodule

// File: tb/tb_hms_clock_ctrl.sv
// Directed bench for hms_clock_ctrl with small divider/debounce parameters.
module tb_hms_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode, btn_up;
    logic [5:0] hour, min, sec, blank;
    logic [1:0] mode;
    logic       tick;

    int checks = 0;
    int errors = 0;
    int ticks;
    int tick_at;
    logic found;

    hms_clock_ctrl #(
        .CLK_HZ   (10),
        .DEB_CYC  (2),
        .BLINK_DIV(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_btn_mode(btn_mode),
        .i_btn_up  (btn_up),
        .o_hour    (hour),
        .o_min     (min),
        .o_sec     (sec),
        .o_mode    (mode),
        .o_blank   (blank),
        .o_tick    (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hold the mode button until o_mode reaches exp; returns on the sample after the step.
    task automatic mode_press(input logic [1:0] exp);
        found    = 1'b0;
        btn_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!found) begin
                @(negedge clk);
                if (mode == exp) found = 1'b1;
            end
        end
        check("mode_step_seen", {31'd0, found}, 32'd1);
        check("mode_value", {30'd0, mode}, {30'd0, exp});
    endtask

    task automatic release_btns(input int n);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic up_press();
        btn_up = 1'b1;
        repeat (6) @(negedge clk);
        btn_up = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_blank(input logic [5:0] v, input string tag);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!found) begin
                @(negedge clk);
                if (blank == v) found = 1'b1;
            end
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hour", hour, 0);
        check("rst_min", min, 0);
        check("rst_sec", sec, 0);
        check("rst_mode", mode, 0);
        check("rst_blank", blank, 0);
        check("rst_tick", tick, 0);

        // Free run: 600 cycles = 60 ticks = 00:01:00.
        rst_n = 1'b1;
        ticks = 0;
        repeat (600) begin
            @(negedge clk);
            if (tick) ticks++;
        end
        check("run_ticks", ticks, 60);
        check("run_min", min, 1);
        check("run_sec", sec, 0);
        check("run_hour", hour, 0);

        // Enter SET_HOUR; time is frozen.
        mode_press(2'd1);
        release_btns(6);
        check("set_sec_frozen", sec, 0);
        check("set_min_frozen", min, 1);

        // Debounce: glitch rejected, long hold counts once, re-press counts again.
        btn_up = 1'b1;
        @(negedge clk);
        btn_up = 1'b0;
        repeat (8) @(negedge clk);
        check("glitch_hour", hour, 0);
        btn_up = 1'b1;
        repeat (50) @(negedge clk);
        check("hold_hour", hour, 1);
        btn_up = 1'b0;
        repeat (5) @(negedge clk);
        btn_up = 1'b1;
        repeat (6) @(negedge clk);
        check("repress_hour", hour, 2);
        btn_up = 1'b0;
        repeat (6) @(negedge clk);
        repeat (21) up_press();
        check("hour_23", hour, 23);
        up_press();
        check("hour_wrap", hour, 0);
        check("hour_wrap_min", min, 1);
        repeat (23) up_press();
        check("hour_23_again", hour, 23);

        // Mode and up together: mode wins.
        btn_up = 1'b1;
        mode_press(2'd2);
        release_btns(6);
        check("combo_hour", hour, 23);
        check("combo_min", min, 1);

        // Blink in SET_MIN; an up event lands where blank would naturally be on.
        wait_blank(6'b001100, "blink_on_seen");
        wait_blank(6'b000000, "blink_off_seen");
        btn_up = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!found) begin
                @(negedge clk);
                if (min != 6'd1) found = 1'b1;
            end
        end
        check("up_min_seen", {31'd0, found}, 32'd1);
        check("up_min", min, 2);
        check("blank_after_up", blank, 0);
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            check("blink_pattern", blank, (((i / 4) % 2) == 1) ? 32'd12 : 32'd0);
        end
        release_btns(6);
        repeat (57) up_press();
        check("min_59", min, 59);
        check("min_no_carry", hour, 23);

        // SET_SEC to 59.
        mode_press(2'd3);
        release_btns(6);
        check("sec_field", sec, 0);
        repeat (59) up_press();
        check("sec_59", sec, 59);

        // Back to RUN: 23:59:59 rolls to 00:00:00 on the first tick.
        mode_press(2'd0);
        check("pre_roll_hour", hour, 23);
        check("pre_roll_min", min, 59);
        check("pre_roll_sec", sec, 59);
        check("run_blank", blank, 0);
        ticks   = 0;
        tick_at = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (tick) begin
                ticks++;
                tick_at = i;
            end
        end
        check("roll_ticks", ticks, 1);
        check("roll_tick_at", tick_at, 9);
        check("roll_hour", hour, 0);
        check("roll_min", min, 0);
        check("roll_sec", sec, 0);

        // Mode cycle; one more tick lands during the release, so sec is 1 when frozen.
        release_btns(12);
        check("pre_cycle_sec", sec, 1);
        mode_press(2'd1);
        release_btns(6);
        mode_press(2'd2);
        release_btns(6);
        mode_press(2'd3);
        repeat (30) @(negedge clk);
        check("cycle_sec_frozen", sec, 1);
        release_btns(6);
        mode_press(2'd0);
        tick_at = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (tick && (tick_at == 0)) tick_at = i;
        end
        check("first_tick_at", tick_at, 9);
        check("first_tick_sec", sec, 2);

        // Asynchronous reset in SET_MIN.
        release_btns(6);
        mode_press(2'd1);
        release_btns(6);
        mode_press(2'd2);
        release_btns(6);
        up_press();
        check("pre_rst_min", min, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hour", hour, 0);
        check("arst_min", min, 0);
        check("arst_sec", sec, 0);
        check("arst_mode", mode, 0);
        check("arst_blank", blank, 0);
        check("arst_tick", tick, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
